// File: rtl/moore_frame_sequencer.sv
// Frame sequencer for a serial-input Moore detector: clears the detector, shifts a word in MSB-first,
// counts MATCH_Y samples and reports the final y. Optional holding buffer: define MOORE_SEQ_PIPE_EN.
module moore_frame_sequencer #(
  parameter int unsigned   WIDTH   = 32,
  parameter int unsigned   GAP     = 1,
  parameter int unsigned   YW      = 3,
  parameter logic [YW-1:0] MATCH_Y = 3'b100,
  localparam int unsigned  CW      = $clog2(WIDTH + 1)
) (
  input  logic             Clk_s,
  input  logic             Rst_s,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             abort,
  output logic             det_x,
  output logic             det_rst,
  input  logic [YW-1:0]    det_y,
  output logic             result_valid,
  output logic [YW-1:0]    result_y,
  output logic [CW-1:0]    hit_count,
  output logic             busy
);

  localparam int unsigned CntMax = (GAP > WIDTH) ? GAP : WIDTH;
  localparam int unsigned KW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    hit_q, hit_d;
  logic [CW-1:0]    hit_count_q, hit_count_d;
  logic [YW-1:0]    result_y_q, result_y_d;
  logic             det_x_q, det_rst_q, ready_q, busy_q, result_valid_q;
  logic             accept, y_match;

`ifdef MOORE_SEQ_PIPE_EN
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
`endif

  assign accept  = word_valid & word_ready;
  assign y_match = (det_y == MATCH_Y);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;
    result_y_d  = result_y_q;
`ifdef MOORE_SEQ_PIPE_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    // IDLE and DONE take the word straight into the shift register; elsewhere it waits here
    if (accept && (state_q != StIdle) && (state_q != StDone)) begin
      buf_d      = word_in;
      buf_full_d = 1'b1;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sreg_d  = word_in;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        hit_d = '0;
        if (cnt_q == KW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StShift: begin
        sreg_d = sreg_q << 1;
        // det_y during bit 0 still reflects the cleared detector, so it is not sampled
        if ((cnt_q != '0) && y_match) hit_d = hit_q + CW'(1);
        if (cnt_q == KW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDrain: begin
        if (y_match) hit_d = hit_q + CW'(1);
        result_y_d  = det_y;
        hit_count_d = hit_d;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
`ifdef MOORE_SEQ_PIPE_EN
        if (buf_full_q) begin
          sreg_d     = buf_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
          state_d    = StClear;
        end else if (accept) begin
          sreg_d  = word_in;
          cnt_d   = '0;
          state_d = StClear;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything and leaves the previous result untouched
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      result_y_d  = result_y_q;
      hit_count_d = hit_count_q;
`ifdef MOORE_SEQ_PIPE_EN
      buf_full_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk_s or posedge Rst_s) begin
    if (Rst_s) begin
      state_q        <= StIdle;
      sreg_q         <= '0;
      cnt_q          <= '0;
      hit_q          <= '0;
      hit_count_q    <= '0;
      result_y_q     <= '0;
      det_x_q        <= 1'b0;
      det_rst_q      <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef MOORE_SEQ_PIPE_EN
      buf_q      <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sreg_q         <= sreg_d;
      cnt_q          <= cnt_d;
      hit_q          <= hit_d;
      hit_count_q    <= hit_count_d;
      result_y_q     <= result_y_d;
      // Outputs are registered copies of the next-state decode
      det_x_q        <= (state_d == StShift) & sreg_d[WIDTH-1];
      det_rst_q      <= (state_d == StClear);
      busy_q         <= (state_d != StIdle);
      result_valid_q <= (state_d == StDone);
`ifdef MOORE_SEQ_PIPE_EN
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ~buf_full_d;
`else
      ready_q    <= (state_d == StIdle);
`endif
    end
  end

  assign word_ready   = ready_q & ~abort & ~Rst_s;
  assign det_rst      = det_rst_q | Rst_s;
  assign det_x        = det_x_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_y     = result_y_q;
  assign hit_count    = hit_count_q;

endmodule

// File: tb/tb_moore_frame_sequencer.sv
// Bench for moore_frame_sequencer: a 3-bit history detector ("last three bits seen") stands in
// for the real Moore detector; results are checked against a bit-window reference model.
module tb_moore_frame_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned GAP     = 1;
  localparam int unsigned YW      = 3;
  localparam logic [2:0]  MATCH_Y = 3'b100;
  localparam int unsigned CW      = $clog2(WIDTH + 1);
  // Edges from the accept edge to the edge that raises result_valid
  localparam int          LAT     = GAP + WIDTH + 1;
`ifdef MOORE_SEQ_PIPE_EN
  localparam int          PERIOD  = GAP + WIDTH + 2;
`else
  localparam int          PERIOD  = GAP + WIDTH + 3;
`endif
  localparam logic [31:0] WORD_A  = 32'h0B2F8455;

  logic             Clk_s, Rst_s;
  logic [WIDTH-1:0] word_in;
  logic             word_valid, word_ready, abort;
  logic             det_x, det_rst;
  logic [YW-1:0]    det_y;
  logic             result_valid;
  logic [YW-1:0]    result_y;
  logic [CW-1:0]    hit_count;
  logic             busy;

  logic [2:0] det_hist_q;
  logic       stub_en;
  logic [2:0] stub_val;

  int total = 0;
  int bad   = 0;
  logic rst_tr [256];
  logic x_tr   [256];

  moore_frame_sequencer dut (
    .Clk_s        (Clk_s),
    .Rst_s        (Rst_s),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .abort        (abort),
    .det_x        (det_x),
    .det_rst      (det_rst),
    .det_y        (det_y),
    .result_valid (result_valid),
    .result_y     (result_y),
    .hit_count    (hit_count),
    .busy         (busy)
  );

  initial Clk_s = 1'b0;
  always #5 Clk_s = ~Clk_s;

  always @(posedge Clk_s) begin
    if (det_rst) det_hist_q <= '0;
    else         det_hist_q <= {det_hist_q[1:0], det_x};
  end
  assign det_y = stub_en ? stub_val : det_hist_q;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // y after bit i is the window (bit i-2, bit i-1, bit i) in shift order, zeros before the frame
  function automatic void ref_frame(input logic [31:0] w, output logic [2:0] y, output int cnt);
    logic [2:0] win;
    cnt = 0;
    y   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      win[2] = (i >= 2) ? w[WIDTH-1-(i-2)] : 1'b0;
      win[1] = (i >= 1) ? w[WIDTH-1-(i-1)] : 1'b0;
      win[0] = w[WIDTH-1-i];
      if (win == MATCH_Y) cnt++;
      y = win;
    end
  endfunction

  // Returns at the first negedge after the accept edge
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    @(negedge Clk_s);
    while (!word_ready && n < 200) begin
      @(negedge Clk_s);
      n++;
    end
    if (!word_ready) check("ready_timeout", 64'd0, 64'd1);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge Clk_s);
    word_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w, output logic [2:0] y, output int cnt,
                           output int lat);
    int i = 0;
    send_word(w);
    lat = -1;
    while (i < 200) begin
      rst_tr[i] = det_rst;
      x_tr[i]   = det_x;
      if (result_valid) begin
        lat = i;
        break;
      end
      @(negedge Clk_s);
      i++;
    end
    if (lat < 0) check("result_timeout", 64'd0, 64'd1);
    y   = result_y;
    cnt = int'(hit_count);
  endtask

  typedef struct {
    logic [31:0] word;
    bit          stub_en;
    logic [2:0]  stub_val;
    logic [2:0]  exp_y;
    int          exp_cnt;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [2:0]  y, ry, prev_y;
    int          cnt, rc, lat, prev_c;
    logic [31:0] rec, w;
    int          hi;

    Rst_s = 1'b0; word_valid = 1'b0; word_in = '0; abort = 1'b0;
    stub_en = 1'b0; stub_val = '0;

    // Reset state before any clock edge
    #1 Rst_s = 1'b1;
    #1;
    check("rst_det_rst", det_rst, 1);
    check("rst_det_x", det_x, 0);
    check("rst_word_ready", word_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge Clk_s);
    Rst_s = 1'b0;

    vecs[0].word = WORD_A;       vecs[0].stub_en = 0; vecs[0].stub_val = '0;
    ref_frame(WORD_A, vecs[0].exp_y, vecs[0].exp_cnt);
    vecs[1].word = 32'hFFFFFFFF; vecs[1].stub_en = 1; vecs[1].stub_val = MATCH_Y;
    vecs[1].exp_y = MATCH_Y;     vecs[1].exp_cnt = 32;
    vecs[2].word = WORD_A;       vecs[2].stub_en = 1; vecs[2].stub_val = 3'b000;
    vecs[2].exp_y = 3'b000;      vecs[2].exp_cnt = 0;
    vecs[3].word = 32'h80000000; vecs[3].stub_en = 0; vecs[3].stub_val = '0;
    vecs[3].exp_y = 3'b000;      vecs[3].exp_cnt = 1;
    vecs[4].word = 32'h00000004; vecs[4].stub_en = 0; vecs[4].stub_val = '0;
    vecs[4].exp_y = 3'b100;      vecs[4].exp_cnt = 1;

    for (int v = 0; v < 5; v++) begin
      stub_en  = vecs[v].stub_en;
      stub_val = vecs[v].stub_val;
      run_frame(vecs[v].word, y, cnt, lat);
      check($sformatf("vec%0d_result_y", v), y, vecs[v].exp_y);
      check($sformatf("vec%0d_hit_count", v), cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_latency", v), lat, LAT);
      if (v == 0) begin
        hi = 0;
        for (int i = 0; i < LAT; i++) if (rst_tr[i]) hi++;
        check("det_rst_cycles", hi, GAP);
        for (int k = 0; k < int'(WIDTH); k++) rec[WIDTH-1-k] = x_tr[GAP+k];
        check("det_x_first8", rec[31:24], 8'b0000_1011);
        check("det_x_frame", rec, WORD_A);
      end
      @(negedge Clk_s);
      check($sformatf("vec%0d_pulse_width", v), result_valid, 0);
      check($sformatf("vec%0d_hold", v), hit_count, vecs[v].exp_cnt);
    end
    stub_en = 1'b0;

    // Random words against the reference model
    for (int r = 0; r < 6; r++) begin
      w = $urandom;
      ref_frame(w, ry, rc);
      run_frame(w, y, cnt, lat);
      check($sformatf("rand%0d_y w=%0h", r, w), y, ry);
      check($sformatf("rand%0d_cnt w=%0h", r, w), cnt, rc);
    end

    // Back-to-back: five words with word_valid held
    begin
      int acc = 0, pulses = 0, extra = 0;
      bit drop = 0;
      int pt[5];
      ref_frame(WORD_A, ry, rc);
      word_in    = WORD_A;
      word_valid = 1'b1;
      for (int c = 0; c < 400 && pulses < 5; c++) begin
        @(negedge Clk_s);
        if (drop) word_valid = 1'b0;
        if (result_valid) begin
          pt[pulses] = c;
          check($sformatf("b2b%0d_y", pulses), result_y, ry);
          check($sformatf("b2b%0d_cnt", pulses), hit_count, rc);
          pulses++;
        end
        if (word_valid && word_ready) begin
          acc++;
          if (acc == 5) drop = 1;
        end
      end
      word_valid = 1'b0;
      check("b2b_pulses", pulses, 5);
      check("b2b_accepts", acc, 5);
      for (int i = 1; i < 5; i++)
        if (i < pulses) check($sformatf("b2b_spacing%0d", i), pt[i] - pt[i-1], PERIOD);
      repeat (60) begin
        @(negedge Clk_s);
        if (result_valid) extra++;
      end
      check("b2b_extra_pulses", extra, 0);
      prev_y = ry;
      prev_c = rc;
    end

    // Abort in SHIFT bit 10
    send_word(32'hFFFF0000);
    repeat (GAP + 10) @(negedge Clk_s);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge Clk_s);
    abort = 1'b0;
    check("abort_busy_after", busy, 0);
    check("abort_keep_y", result_y, prev_y);
    check("abort_keep_cnt", hit_count, prev_c);
    begin
      int pulses = 0;
      repeat (50) begin
        @(negedge Clk_s);
        if (result_valid) pulses++;
      end
      check("abort_no_result", pulses, 0);
    end

    // Abort in IDLE blocks the handshake
    @(negedge Clk_s);
    abort = 1'b1; word_valid = 1'b1; word_in = WORD_A;
    #1 check("abort_idle_ready", word_ready, 0);
    @(negedge Clk_s);
    abort = 1'b0; word_valid = 1'b0;
    check("abort_idle_busy", busy, 0);

    ref_frame(WORD_A, ry, rc);
    run_frame(WORD_A, y, cnt, lat);
    check("post_abort_y", y, ry);
    check("post_abort_cnt", cnt, rc);

    // Asynchronous reset between edges, mid-SHIFT on a 1 bit
    send_word(WORD_A);
    repeat (GAP + 4) @(negedge Clk_s);
    check("pre_rst_det_x", det_x, 1);
    #2 Rst_s = 1'b1;
    #1;
    check("arst_det_rst", det_rst, 1);
    check("arst_det_x", det_x, 0);
    check("arst_word_ready", word_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_result_valid", result_valid, 0);
    check("arst_hit_count", hit_count, 0);
    @(negedge Clk_s);
    Rst_s = 1'b0;
    run_frame(WORD_A, y, cnt, lat);
    check("post_rst_y", y, ry);
    check("post_rst_cnt", cnt, rc);
    check("post_rst_latency", lat, LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
